// File: rtl/sparam_sweep_sequencer.sv
// Stepped-frequency S-parameter sweep sequencer: programs the source per point, settles,
// runs the capture handshake for S11 (and optionally S21) and streams each result out.
module sparam_sweep_sequencer #(
  parameter int FW  = 32,
  parameter int NW  = 10,
  parameter int SW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [NW-1:0] n_points,
  input  logic [SW-1:0] settle_cycles,
  input  logic          dual,
  output logic [FW-1:0] freq_word,
  output logic          freq_load,
  output logic          port_sel,
  output logic          cap_req,
  input  logic          cap_ack,
  input  logic [DW-1:0] cap_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [NW-1:0] res_index,
  output logic          res_param,
  output logic          busy,
  output logic          done,
  output logic          err_timeout
);

  localparam int TW = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state_q,     state_d;
  logic [FW-1:0] freq_q,      freq_d;
  logic [FW-1:0] step_q,      step_d;
  logic [NW-1:0] npts_q,      npts_d;
  logic [SW-1:0] settle_q,    settle_d;
  logic          dual_q,      dual_d;
  logic [NW-1:0] idx_q,       idx_d;
  logic [SW-1:0] cnt_q,       cnt_d;
  logic [TW-1:0] tmo_q,       tmo_d;
  logic          port_q,      port_d;
  logic [DW-1:0] res_data_q,  res_data_d;
  logic [NW-1:0] res_index_q, res_index_d;
  logic          res_param_q, res_param_d;
  logic          err_q,       err_d;
  logic          zdone_q,     zdone_d;

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    step_d      = step_q;
    npts_d      = npts_q;
    settle_d    = settle_q;
    dual_d      = dual_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    port_d      = port_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    res_param_d = res_param_q;
    err_d       = err_q;
    zdone_d     = 1'b0;

    // A sweep already in DONE finishes normally, so abort there cannot double the done pulse.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_d = 1'b0;
            if (n_points != '0) begin
              freq_d   = f_start;
              step_d   = f_step;
              npts_d   = n_points;
              settle_d = settle_cycles;
              dual_d   = dual;
              idx_d    = '0;
              port_d   = 1'b0;
              state_d  = S_LOAD;
            end else begin
              zdone_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          cnt_d   = settle_q;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            tmo_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
        S_CAPTURE: begin
          if (cap_ack) begin
            res_data_d  = cap_data;
            res_index_d = idx_q;
            res_param_d = port_q;
            state_d     = S_EMIT;
          end else if (tmo_q == TW'(TMO - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            if (!port_q && dual_q) begin
              // Second port of the same point: re-settle without touching the source.
              port_d  = 1'b1;
              cnt_d   = settle_q;
              state_d = S_SETTLE;
            end else if (idx_q == npts_q - NW'(1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + NW'(1);
              freq_d  = freq_q + step_q;
              port_d  = 1'b0;
              state_d = S_LOAD;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_DONE) port_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      step_q      <= '0;
      npts_q      <= '0;
      settle_q    <= '0;
      dual_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      port_q      <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_param_q <= 1'b0;
      err_q       <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      step_q      <= step_d;
      npts_q      <= npts_d;
      settle_q    <= settle_d;
      dual_q      <= dual_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      port_q      <= port_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      res_param_q <= res_param_d;
      err_q       <= err_d;
      zdone_q     <= zdone_d;
    end
  end

  assign freq_word   = freq_q;
  assign freq_load   = (state_q == S_LOAD);
  assign port_sel    = port_q;
  assign cap_req     = (state_q == S_CAPTURE);
  assign res_valid   = (state_q == S_EMIT);
  assign res_data    = res_data_q;
  assign res_index   = res_index_q;
  assign res_param   = res_param_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE) | zdone_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sparam_sweep_sequencer.sv
// Bench for sparam_sweep_sequencer: randomized capture/ready responders against an
// arithmetic model of the expected frequency list, result order and settle timing.
module tb_sparam_sweep_sequencer;
  localparam int FW = 32, NW = 10, SW = 16, DW = 16, TMO = 1023;

  logic          clk = 1'b0;
  logic          rst, start, abort, dual, cap_ack, res_ready;
  logic [FW-1:0] f_start, f_step;
  logic [NW-1:0] n_points;
  logic [SW-1:0] settle_cycles;
  logic [DW-1:0] cap_data;
  logic [FW-1:0] freq_word;
  logic          freq_load, port_sel, cap_req, res_valid, res_param, busy, done, err_timeout;
  logic [DW-1:0] res_data;
  logic [NW-1:0] res_index;

  always #5 clk = ~clk;

  sparam_sweep_sequencer #(.FW(FW), .NW(NW), .SW(SW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f_start(f_start), .f_step(f_step),
    .n_points(n_points), .settle_cycles(settle_cycles), .dual(dual), .freq_word(freq_word),
    .freq_load(freq_load), .port_sel(port_sel), .cap_req(cap_req), .cap_ack(cap_ack),
    .cap_data(cap_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_index(res_index), .res_param(res_param), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] obs_freq[$];
  logic [DW-1:0] obs_data[$];
  logic [DW-1:0] ack_data[$];
  int            obs_idx[$];
  int            obs_par[$];
  int            obs_port[$];
  int            obs_gap[$];
  int            done_cnt, stable_err, overlap, req_cycles, first_wait, cyc, done_at;
  bit            finished, busy_after, err_at_done, port_at_done, busy_seen, err_first;
  logic [2:0]    post_abort;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one sweep and records everything observed; the test tasks judge the records.
  task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fst, input int np,
                           input int st, input bit dl, input int ack_dly, input int rmode,
                           input int abort_cap, input int budget);
    int         req_cnt, vcnt, n_caps, trig, done_cyc;
    bit         done_seen, prev_valid, prev_ready, prev_req, abort_last;
    logic [DW+NW:0] prev_vec;
    obs_freq.delete(); obs_data.delete(); ack_data.delete(); obs_idx.delete();
    obs_par.delete(); obs_port.delete(); obs_gap.delete();
    done_cnt = 0; stable_err = 0; overlap = 0; req_cycles = 0; first_wait = 0; done_at = -1;
    busy_seen = 0; err_at_done = 0; port_at_done = 0; post_abort = 3'b111;
    req_cnt = 0; vcnt = 0; n_caps = 0; trig = 0; done_cyc = 0; done_seen = 0;
    prev_valid = 0; prev_ready = 0; prev_req = 0; abort_last = 0; prev_vec = '0;

    f_start = fs; f_step = fst; n_points = NW'(np); settle_cycles = SW'(st); dual = dl;
    start = 1'b1;
    tick;
    start = 1'b0;
    // Scramble the configuration inputs: the sweep must run from the latched copy.
    f_start = $urandom; f_step = $urandom; n_points = NW'($urandom);
    settle_cycles = SW'($urandom_range(0, 40)); dual = 1'($urandom % 2);
    cyc = 1;
    err_first = err_timeout;

    while (cyc < budget && !(done_seen && cyc > done_cyc + 3)) begin
      if (abort_last) post_abort = {cap_req, res_valid, done};
      if (busy) busy_seen = 1;
      if (freq_load) begin
        obs_freq.push_back(freq_word);
        trig = cyc;
      end
      if (cap_req && !prev_req) begin
        obs_port.push_back(int'(port_sel));
        obs_gap.push_back(cyc - trig);
      end
      if (cap_req) req_cycles++;
      if (cap_req && res_valid) overlap++;
      if (res_valid && prev_valid && !prev_ready && {res_data, res_index, res_param} !== prev_vec)
        stable_err++;
      if (done) begin
        done_cnt++;
        if (!done_seen) begin
          done_seen = 1; done_cyc = cyc; done_at = cyc;
          err_at_done = err_timeout; port_at_done = port_sel;
        end
      end

      req_cnt  = cap_req ? req_cnt + 1 : 0;
      cap_ack  = 1'b0;
      abort    = 1'b0;
      cap_data = DW'($urandom);
      if (cap_req && ack_dly > 0 && req_cnt == ack_dly) begin
        cap_ack = 1'b1;
        if (n_caps == abort_cap) abort = 1'b1;
        else ack_data.push_back(cap_data);
        n_caps++;
      end
      abort_last = abort;

      if (res_valid) vcnt++;
      if (rmode == 0)      res_ready = 1'b1;
      else if (rmode == 1) res_ready = 1'($urandom % 2);
      else                 res_ready = (vcnt > 10);
      if (res_valid && res_ready) begin
        obs_data.push_back(res_data);
        obs_idx.push_back(int'(res_index));
        obs_par.push_back(int'(res_param));
        if (obs_data.size() == 1) first_wait = vcnt;
        trig = cyc;
      end
      start = (cyc == 3 && busy);

      prev_valid = res_valid; prev_ready = res_ready; prev_req = cap_req;
      prev_vec = {res_data, res_index, res_param};
      tick;
      cyc++;
    end
    finished = done_seen;
    busy_after = busy;
    start = 0; abort = 0; cap_ack = 0; res_ready = 0;
    $display("sweep np=%0d dual=%0d settle=%0d: %0d loads, %0d results, %0d done pulses",
             np, dl, st, obs_freq.size(), obs_data.size(), done_cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; dual = 0; cap_ack = 0; res_ready = 0;
    f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0; cap_data = '0;
    repeat (3) tick;
    rst = 1'b0;
    n_checks++;
    if ({freq_word, freq_load, port_sel, cap_req, res_valid, res_data, res_index, res_param,
         busy, done, err_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs (freq=%h busy=%b) required all 0",
                         freq_word, busy);
    end
    tick;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got busy/done=%b%b required 00", busy, done);
    end
  endtask

  task automatic test_single_port;
    logic [FW-1:0] e;
    run_sweep(32'd100, 32'd25, 4, 3, 1'b0, 2, 0, -1, 500);
    n_checks++;
    if (!finished || done_cnt != 1) begin
      n_fail++; $display("FAIL single_done: got finished=%0d pulses=%0d required 1/1", finished, done_cnt);
    end
    n_checks++;
    if (obs_freq.size() != 4) begin
      n_fail++; $display("FAIL single_loads: got %0d required 4", obs_freq.size());
    end
    for (int i = 0; i < obs_freq.size() && i < 4; i++) begin
      e = 32'd100 + 32'd25 * 32'(i);
      n_checks++;
      if (obs_freq[i] !== e) begin
        n_fail++; $display("FAIL single_freq[%0d]: got %0d required %0d", i, obs_freq[i], e);
      end
    end
    n_checks++;
    if (obs_data.size() != 4) begin
      n_fail++; $display("FAIL single_results: got %0d required 4", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < ack_data.size(); k++) begin
      n_checks++;
      if (obs_idx[k] != k || obs_par[k] != 0 || obs_data[k] !== ack_data[k]) begin
        n_fail++; $display("FAIL single_result[%0d]: got idx=%0d par=%0d data=%h required %0d/0/%h",
                           k, obs_idx[k], obs_par[k], obs_data[k], k, ack_data[k]);
      end
    end
    for (int g = 0; g < obs_gap.size(); g++) begin
      n_checks++;
      if (obs_gap[g] != 3 + 2) begin
        n_fail++; $display("FAIL single_settle[%0d]: got %0d cycles to cap_req required 5", g, obs_gap[g]);
      end
    end
    n_checks++;
    if (busy_after !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%b required 0", busy_after);
    end
  endtask

  task automatic test_dual;
    run_sweep(32'd500, 32'd7, 2, 1, 1'b1, 1, 1, -1, 500);
    n_checks++;
    if (obs_freq.size() != 2 || done_cnt != 1) begin
      n_fail++; $display("FAIL dual_loads: got loads=%0d done=%0d required 2/1", obs_freq.size(), done_cnt);
    end
    n_checks++;
    if (obs_data.size() != 4) begin
      n_fail++; $display("FAIL dual_results: got %0d required 4", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < ack_data.size(); k++) begin
      n_checks++;
      if (obs_idx[k] != k / 2 || obs_par[k] != k % 2 || obs_data[k] !== ack_data[k]) begin
        n_fail++; $display("FAIL dual_result[%0d]: got idx=%0d par=%0d data=%h required %0d/%0d/%h",
                           k, obs_idx[k], obs_par[k], obs_data[k], k / 2, k % 2, ack_data[k]);
      end
    end
    for (int k = 0; k < obs_port.size(); k++) begin
      n_checks++;
      if (obs_port[k] != k % 2 || obs_gap[k] != 1 + 2) begin
        n_fail++; $display("FAIL dual_port[%0d]: got port=%0d gap=%0d required %0d/3",
                           k, obs_port[k], obs_gap[k], k % 2);
      end
    end
    n_checks++;
    if (port_at_done !== 1'b0) begin
      n_fail++; $display("FAIL dual_port_done: got %b required 0", port_at_done);
    end
  endtask

  task automatic test_backpressure;
    run_sweep(32'd10, 32'd10, 2, 2, 1'b0, 3, 2, -1, 500);
    n_checks++;
    if (stable_err != 0 || overlap != 0) begin
      n_fail++; $display("FAIL bp_stable: got unstable=%0d req_overlap=%0d required 0/0", stable_err, overlap);
    end
    n_checks++;
    if (first_wait != 11) begin
      n_fail++; $display("FAIL bp_wait: got %0d valid cycles required 11", first_wait);
    end
    n_checks++;
    if (!finished || obs_data.size() != 2) begin
      n_fail++; $display("FAIL bp_resume: got finished=%0d results=%0d required 1/2", finished, obs_data.size());
    end
  endtask

  task automatic test_timeout;
    run_sweep(32'd1, 32'd1, 3, 2, 1'b0, 0, 0, -1, 1500);
    n_checks++;
    if (req_cycles != TMO) begin
      n_fail++; $display("FAIL tmo_req_len: got %0d required %0d", req_cycles, TMO);
    end
    n_checks++;
    if (err_at_done !== 1'b1 || done_cnt != 1 || obs_data.size() != 0) begin
      n_fail++; $display("FAIL tmo_done: got err=%b done=%0d results=%0d required 1/1/0",
                         err_at_done, done_cnt, obs_data.size());
    end
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky: got %b required 1", err_timeout);
    end
    run_sweep(32'd5, 32'd5, 1, 0, 1'b0, 1, 0, -1, 200);
    n_checks++;
    if (err_first !== 1'b0 || !finished) begin
      n_fail++; $display("FAIL tmo_clear: got err=%b finished=%0d required 0/1", err_first, finished);
    end
  endtask

  task automatic test_abort;
    run_sweep(32'd0, 32'd1, 4, 1, 1'b0, 2, 0, 2, 500);
    n_checks++;
    if (obs_data.size() != 2 || obs_freq.size() != 3) begin
      n_fail++; $display("FAIL abort_results: got results=%0d loads=%0d required 2/3",
                         obs_data.size(), obs_freq.size());
    end
    for (int k = 0; k < obs_data.size() && k < ack_data.size(); k++) begin
      n_checks++;
      if (obs_idx[k] != k || obs_data[k] !== ack_data[k]) begin
        n_fail++; $display("FAIL abort_result[%0d]: got idx=%0d data=%h required %0d/%h",
                           k, obs_idx[k], obs_data[k], k, ack_data[k]);
      end
    end
    n_checks++;
    if (post_abort !== 3'b001) begin
      n_fail++; $display("FAIL abort_next: got req/valid/done=%b required 001", post_abort);
    end
    n_checks++;
    if (done_cnt != 1 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got done=%0d busy=%b required 1/0", done_cnt, busy_after);
    end
  endtask

  task automatic test_zero_points;
    run_sweep(32'd9, 32'd9, 0, 0, 1'b0, 1, 0, -1, 50);
    n_checks++;
    if (done_cnt != 1 || done_at != 1) begin
      n_fail++; $display("FAIL zero_done: got pulses=%0d at cycle %0d required 1 at 1", done_cnt, done_at);
    end
    n_checks++;
    if (obs_freq.size() != 0 || busy_seen) begin
      n_fail++; $display("FAIL zero_quiet: got loads=%0d busy_seen=%0d required 0/0", obs_freq.size(), busy_seen);
    end
  endtask

  task automatic test_wrap;
    logic [FW-1:0] e;
    run_sweep(32'hFFFF_FFF0, 32'h20, 3, 0, 1'b0, 1, 0, -1, 300);
    n_checks++;
    if (obs_freq.size() != 3) begin
      n_fail++; $display("FAIL wrap_loads: got %0d required 3", obs_freq.size());
    end
    for (int i = 0; i < obs_freq.size() && i < 3; i++) begin
      e = 32'hFFFF_FFF0 + 32'h20 * 32'(i);
      n_checks++;
      if (obs_freq[i] !== e) begin
        n_fail++; $display("FAIL wrap_freq[%0d]: got %h required %h", i, obs_freq[i], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int guard, dcnt, bcnt;
    f_start = 32'd77; f_step = 32'd3; n_points = NW'(3); settle_cycles = SW'(20); dual = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    guard = 0;
    while (!freq_load && guard < 20) begin tick; guard++; end
    repeat (3) tick;
    n_checks++;
    if ({busy, cap_req, freq_load} !== 3'b100 || freq_word !== 32'd77) begin
      n_fail++; $display("FAIL rstmid_settle: got busy/req/load=%b%b%b freq=%0d required 100/77",
                         busy, cap_req, freq_load, freq_word);
    end
    rst = 1'b1;
    tick;
    n_checks++;
    if ({freq_word, freq_load, port_sel, cap_req, res_valid, res_data, res_index, res_param,
         busy, done, err_timeout} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got freq=%h busy=%b done=%b required all 0",
                         freq_word, busy, done);
    end
    rst = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (30) begin
      tick;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    n_checks++;
    if (dcnt != 0 || bcnt != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got done=%0d busy=%0d required 0/0", dcnt, bcnt);
    end
  endtask

  task automatic test_random;
    logic [FW-1:0] fs, fst, e;
    int np, st, nr, ak;
    bit dl;
    for (int it = 0; it < 8; it++) begin
      fs = $urandom; fst = $urandom; np = $urandom_range(1, 6); st = $urandom_range(0, 5);
      dl = 1'($urandom % 2); ak = $urandom_range(1, 4);
      nr = np * (dl ? 2 : 1);
      run_sweep(fs, fst, np, st, dl, ak, 1, -1, 2000);
      n_checks++;
      if (!finished || done_cnt != 1 || obs_freq.size() != np || obs_data.size() != nr) begin
        n_fail++; $display("FAIL rand%0d_counts: got done=%0d loads=%0d results=%0d required 1/%0d/%0d",
                           it, done_cnt, obs_freq.size(), obs_data.size(), np, nr);
      end
      for (int i = 0; i < obs_freq.size() && i < np; i++) begin
        e = fs + fst * 32'(i);
        n_checks++;
        if (obs_freq[i] !== e) begin
          n_fail++; $display("FAIL rand%0d_freq[%0d]: got %h required %h", it, i, obs_freq[i], e);
        end
      end
      for (int k = 0; k < obs_data.size() && k < ack_data.size() && k < nr; k++) begin
        n_checks++;
        if (obs_idx[k] != k / (dl ? 2 : 1) || obs_par[k] != (dl ? k % 2 : 0) ||
            obs_data[k] !== ack_data[k]) begin
          n_fail++; $display("FAIL rand%0d_result[%0d]: got idx=%0d par=%0d data=%h required data %h",
                             it, k, obs_idx[k], obs_par[k], obs_data[k], ack_data[k]);
        end
      end
      for (int g = 0; g < obs_gap.size(); g++) begin
        n_checks++;
        if (obs_gap[g] != st + 2) begin
          n_fail++; $display("FAIL rand%0d_settle[%0d]: got %0d required %0d", it, g, obs_gap[g], st + 2);
        end
      end
      n_checks++;
      if (stable_err != 0 || overlap != 0) begin
        n_fail++; $display("FAIL rand%0d_stable: got unstable=%0d overlap=%0d required 0/0",
                           it, stable_err, overlap);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_port;
    test_dual;
    test_backpressure;
    test_timeout;
    test_abort;
    test_zero_points;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparam_sweep_sequencer.md
Name: sparam_sweep_sequencer

Overview:
Sequences a stepped-frequency S-parameter sweep of the spiral band-pass filter test fixture. For each frequency point it programs the source frequency word, waits a settle interval, and triggers a capture handshake. It captures S11 (reflection, port 1) and optionally S21 (transmission, port 2), then streams each result out on a valid/ready interface. It sits between the host control registers and the source/receiver datapath.

Parameters:
FW, 32, frequency word width
NW, 10, point-count/index width
SW, 16, settle counter width
DW, 16, capture data width
TMO, 1023, capture timeout in cycles (wait on cap_ack)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin sweep (ignored unless IDLE)
abort  in  1  pulse; terminate sweep
f_start  in  FW  first frequency word
f_step  in  FW  frequency increment per point
n_points  in  NW  number of points (0 => immediate done)
settle_cycles  in  SW  settle wait per point/port
dual  in  1  1: capture S11 then S21 per point; 0: S11 only
freq_word  out  FW  current source frequency
freq_load  out  1  one-cycle pulse when freq_word changes
port_sel  out  1  0=S11 (port 1), 1=S21 (port 2)
cap_req  out  1  capture request (level)
cap_ack  in  1  capture complete; cap_data valid same cycle
cap_data  in  DW  captured magnitude
res_valid  out  1  result valid
res_ready  in  1  downstream accepts
res_data  out  DW  result magnitude
res_index  out  NW  point index of result
res_param  out  1  0=S11, 1=S21
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at sweep end (normal or abort)
err_timeout  out  1  sticky; cleared by rst or next accepted start

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0.
- IDLE: on start with n_points>0 -> LOAD and latch all configuration inputs; inputs are not sampled again mid-sweep. On start with n_points==0 -> done pulse next cycle, remain IDLE.
- LOAD: freq_word = f_start + idx*f_step, computed as an accumulator and wrapping mod 2^FW. Pulse freq_load for 1 cycle. port_sel=0. -> SETTLE.
- SETTLE: counter runs from settle_cycles down to 0; exit when it reaches 0, so the state lasts settle_cycles+1 cycles (settle_cycles=0 => 1 cycle). -> CAPTURE.
- CAPTURE: cap_req=1 while waiting. On cap_ack, register cap_data/idx/port_sel into the result registers, drop cap_req the next cycle, -> EMIT. If no ack within TMO cycles: set err_timeout, drop cap_req, -> DONE.
- EMIT: res_valid=1 with data stable until res_ready. A result is transferred on res_valid&res_ready. Then:
  - if port_sel==0 and dual: set port_sel=1, -> SETTLE (freq_word unchanged, no freq_load).
  - else if idx==n_points-1: -> DONE.
  - else idx++, freq_word += f_step, -> LOAD.
- DONE: done pulse 1 cycle, port_sel=0, freq_word held; -> IDLE.
- abort in any non-IDLE state: cap_req and res_valid drop next cycle, any pending result is discarded, -> DONE. Abort takes priority over cap_ack and over handshake in the same cycle.
- start while busy is ignored. rst mid-sweep returns everything to reset values immediately, with no done pulse.
- Minimum per capture: LOAD(1)+SETTLE(s+1)+CAPTURE(>=1)+EMIT(>=1).
- Result count = n_points*(dual?2:1). res_index runs 0..n_points-1 in order. For dual sweeps, S11 precedes S21 for each point.

Test Plan:
- Single-port sweep: f_start=100, f_step=25, n_points=4, dual=0, settle=3, cap_ack 2 cycles after req, res_ready=1 -> freq_words 100,125,150,175; 4 results with idx 0..3 and param 0; 4 freq_load pulses; done once.
- Dual sweep: n_points=2, dual=1 -> results (0,S11),(0,S21),(1,S11),(1,S21); only 2 freq_load pulses; port_sel toggles 0,1,0,1.
- Backpressure: res_ready held 0 for 10 cycles in EMIT -> res_data/index stable; no new cap_req; sweep resumes after the handshake.
- Timeout: TMO=1023, cap_ack never asserted -> cap_req drops after 1023 cycles; err_timeout=1; done pulse; next start clears err_timeout.
- Abort with simultaneous cap_ack mid-point 2 -> no result emitted for that capture; done pulse; IDLE next.
- Edges: n_points=0 -> done only, no freq_load. f_start=0xFFFFFFF0, f_step=0x20 -> second word 0x10 (wraps). rst during SETTLE -> all outputs 0, no done pulse.
